mcp7940n_target: RTL
====================

MCP7940N_TARGET -- requirements
Module: mcp7940n_target

Interface
REQ-001 SHALL have parameter c_addr, default 7'h6F, 7-bit I2C target address answered.
REQ-002 SHALL have parameter c_sync, default 3, SDA/SCL synchronizer depth (clk cycles).
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port reset_n  input  1  reset; reset is asynchronous and active-low.
REQ-005 SHALL have port scl  input  1  I2C clock from initiator; the target never drives or stretches it.
REQ-006 SHALL have port sda  inout  1  I2C data; open-drain: driven 0 or high-Z, never driven 1.
REQ-007 SHALL have port regs_o  output  64  register file {R7..R0}, R0 in [7:0]; R0-R6 = SS,MM,HH,WD,DD,MM,YY BCD, R7 = control.
REQ-008 SHALL have port wr_strobe  output  1  one-cycle pulse when a data byte is written to the register file.
REQ-009 SHALL have port wr_addr  output  3  register index of the last write, valid with wr_strobe.
REQ-010 SHALL have port busy  output  1  high from addressed START until STOP/NACK/mismatch.

Function
REQ-011 SHALL pass scl and sda through c_sync flip-flops before any edge detection; clk SHALL be at least 20x SCL frequency.
REQ-012 SHALL detect START as synced SDA falling while synced SCL high, and STOP as synced SDA rising while synced SCL high, in any state.
REQ-013 SHALL sample SDA on synced SCL rising edges and change its own SDA drive only on synced SCL falling edges.
REQ-014 SHALL implement states IDLE, DEVADDR, ACK_DEV, PTR, ACK_PTR, WDATA, ACK_WDATA, RDATA, MACK.
REQ-015 START (incl. repeated START) from any state SHALL clear bit counter and go to DEVADDR; STOP from any state SHALL go to IDLE and release SDA.
REQ-016 DEVADDR SHALL shift 8 bits MSB first; on match of bits[7:1] with c_addr go to ACK_DEV, else release SDA and go to IDLE until next START.
REQ-017 ACK_DEV SHALL drive SDA low from the SCL fall after bit 8 to the SCL fall after bit 9; then go to RDATA if R/W=1, else PTR.
REQ-018 PTR SHALL shift 8 bits; pointer SHALL take bits[2:0] (upper bits ignored); ACK_PTR acks, then goes to WDATA.
REQ-019 WDATA SHALL shift 8 bits; ACK_WDATA SHALL write byte to R[pointer], pulse wr_strobe with wr_addr=pointer once at the 8th SCL rise, ack, then increment pointer and return to WDATA.
REQ-020 RDATA SHALL latch R[pointer] into a shift register at entry, drive bit 7 at the same SCL fall that ends the ack, shift MSB first (0 -> SDA low, 1 -> release), release SDA after the 8th bit's SCL fall.
REQ-021 MACK SHALL sample SDA at the 9th SCL rise: 0 -> increment pointer, back to RDATA; 1 (NACK) -> IDLE, SDA released.
REQ-022 Pointer SHALL be 3 bits, wrap 7 -> 0 on increment, persist across transactions, reset to 0.
REQ-023 Register writes SHALL be full 8-bit, no masking; regs_o SHALL reflect a write on the cycle after wr_strobe.
REQ-024 STOP or START mid-byte SHALL discard the partial byte: no register write, no pointer change.
REQ-025 busy SHALL rise with the address-match ACK and fall on STOP, NACK, or non-matching address.

Reset
REQ-026 While reset_n low: state IDLE, SDA released, pointer 0, R0-R7 0x00, regs_o 0, wr_strobe 0, wr_addr 0, busy 0, synchronizers set to 1 (bus idle).
REQ-027 Reset asserted mid-transaction SHALL release SDA immediately (asynchronously); after deassert, the block SHALL ignore the bus until the next START.

Verification
REQ-028 Write: START, 0xDE, 0x00, 0x45, 0x30, 0x12, STOP -> all ACKed; R0=0x45,R1=0x30,R2=0x12; three wr_strobe pulses, wr_addr 0,1,2; pointer=3.
REQ-029 Wrap: START, 0xDE, 0x07, 0xAA, 0xBB, STOP -> R7=0xAA, R0=0xBB, pointer=1.
REQ-030 Random read: with R5=0x11,R6=0x24 -> START,0xDE,0x05, Sr,0xDF, read ACK, read NACK, STOP -> bytes 0x11 then 0x24; SDA released after NACK; busy low after.
REQ-031 Mismatch: START, 0xA0 -> 9th bit reads 1 (NACK), no SDA drive, busy stays 0, regs unchanged.
REQ-032 Abort: START,0xDE,0x02, 4 data bits, STOP -> R2 unchanged, no wr_strobe, pointer=2.
REQ-033 Reset mid-read while driving SDA low -> SDA high-Z within reset assertion, regs_o=0, next full transaction behaves as REQ-028.

Source files
------------

// File: rtl/mcp7940n_target.sv
`default_nettype none
// ============================================================================
// mcp7940n_target : I2C target exposing an 8-byte RTC-style register file
// Revision 1.0
// ============================================================================
module mcp7940n_target #(
    parameter logic [6:0] c_addr = 7'h6F,
    parameter int         c_sync = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        scl,
    inout  wire         sda,
    output logic [63:0] regs_o,
    output logic        wr_strobe,
    output logic [2:0]  wr_addr,
    output logic        busy
);

    typedef enum logic [3:0] {
        IDLE, DEVADDR, ACK_DEV, PTR, ACK_PTR, WDATA, ACK_WDATA, RDATA, MACK
    } state_t;

    // bit_cnt value parked in RDATA after a master ACK: reload on the next fall
    localparam logic [3:0] c_reload = 4'd9;

    state_t              state_q, state_d;
    logic [c_sync-1:0]   scl_sync_q, scl_sync_d;
    logic [c_sync-1:0]   sda_sync_q, sda_sync_d;
    logic                scl_prev_q, scl_prev_d;
    logic                sda_prev_q, sda_prev_d;
    logic [3:0]          bit_cnt_q, bit_cnt_d;
    logic [7:0]          shreg_q, shreg_d;
    logic [2:0]          ptr_q, ptr_d;
    logic                sda_oe_q, sda_oe_d;
    logic                busy_q, busy_d;
    logic                wr_strobe_q, wr_strobe_d;
    logic [2:0]          wr_addr_q, wr_addr_d;
    logic [7:0][7:0]     regs_q, regs_d;

    logic       scl_s, sda_s;
    logic       scl_rise, scl_fall, start_det, stop_det;
    logic       last_bit;
    logic [7:0] byte_in;

    always_comb begin
        scl_s     = scl_sync_q[c_sync-1];
        sda_s     = sda_sync_q[c_sync-1];
        scl_rise  = scl_s & ~scl_prev_q;
        scl_fall  = ~scl_s & scl_prev_q;
        start_det = scl_s & scl_prev_q & ~sda_s & sda_prev_q;
        stop_det  = scl_s & scl_prev_q & sda_s & ~sda_prev_q;
        byte_in   = {shreg_q[6:0], sda_s};
        last_bit  = (bit_cnt_q == 4'd7);

        scl_sync_d  = {scl_sync_q[c_sync-2:0], scl};
        sda_sync_d  = {sda_sync_q[c_sync-2:0], sda};
        scl_prev_d  = scl_s;
        sda_prev_d  = sda_s;
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        ptr_d       = ptr_q;
        sda_oe_d    = sda_oe_q;
        busy_d      = busy_q;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        regs_d      = regs_q;

        // Commit lands one cycle after the strobe; shreg is stable until the next SCL fall
        if (wr_strobe_q) begin
            regs_d[wr_addr_q] = shreg_q;
        end

        unique case (state_q)
            IDLE: ;
            DEVADDR: begin
                if (scl_rise) begin
                    shreg_d   = byte_in;
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (last_bit) begin
                        if (byte_in[7:1] == c_addr) begin
                            state_d = ACK_DEV;
                        end else begin
                            state_d  = IDLE;
                            busy_d   = 1'b0;
                            sda_oe_d = 1'b0;
                        end
                    end
                end
            end
            ACK_DEV: begin
                if (scl_fall) begin
                    bit_cnt_d = 4'd0;
                    if (!sda_oe_q) begin
                        sda_oe_d = 1'b1;
                        busy_d   = 1'b1;
                    end else if (shreg_q[0]) begin
                        state_d  = RDATA;
                        shreg_d  = regs_q[ptr_q];
                        sda_oe_d = ~regs_q[ptr_q][7];
                    end else begin
                        state_d  = PTR;
                        sda_oe_d = 1'b0;
                    end
                end
            end
            PTR: begin
                if (scl_rise) begin
                    shreg_d   = byte_in;
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (last_bit) begin
                        ptr_d   = byte_in[2:0];
                        state_d = ACK_PTR;
                    end
                end
            end
            ACK_PTR: begin
                if (scl_fall) begin
                    if (!sda_oe_q) begin
                        sda_oe_d = 1'b1;
                    end else begin
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = 4'd0;
                        state_d   = WDATA;
                    end
                end
            end
            WDATA: begin
                if (scl_rise) begin
                    shreg_d   = byte_in;
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (last_bit) begin
                        wr_strobe_d = 1'b1;
                        wr_addr_d   = ptr_q;
                        state_d     = ACK_WDATA;
                    end
                end
            end
            ACK_WDATA: begin
                if (scl_fall) begin
                    if (!sda_oe_q) begin
                        sda_oe_d = 1'b1;
                    end else begin
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = 4'd0;
                        ptr_d     = ptr_q + 3'd1;
                        state_d   = WDATA;
                    end
                end
            end
            RDATA: begin
                if (scl_rise) begin
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end
                if (scl_fall) begin
                    if (bit_cnt_q == c_reload) begin
                        shreg_d   = regs_q[ptr_q];
                        sda_oe_d  = ~regs_q[ptr_q][7];
                        bit_cnt_d = 4'd0;
                    end else if (bit_cnt_q == 4'd8) begin
                        sda_oe_d = 1'b0;
                        state_d  = MACK;
                    end else begin
                        sda_oe_d = ~shreg_q[6];
                        shreg_d  = {shreg_q[6:0], 1'b0};
                    end
                end
            end
            MACK: begin
                if (scl_rise) begin
                    if (sda_s) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end else begin
                        ptr_d     = ptr_q + 3'd1;
                        bit_cnt_d = c_reload;
                        state_d   = RDATA;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Bus conditions override whatever the byte engine decided this cycle
        if (start_det) begin
            state_d   = DEVADDR;
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b0;
        end else if (stop_det) begin
            state_d  = IDLE;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            scl_sync_q  <= '1;
            sda_sync_q  <= '1;
            scl_prev_q  <= 1'b1;
            sda_prev_q  <= 1'b1;
            bit_cnt_q   <= 4'd0;
            shreg_q     <= 8'h00;
            ptr_q       <= 3'd0;
            sda_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= 3'd0;
            regs_q      <= '0;
        end else begin
            state_q     <= state_d;
            scl_sync_q  <= scl_sync_d;
            sda_sync_q  <= sda_sync_d;
            scl_prev_q  <= scl_prev_d;
            sda_prev_q  <= sda_prev_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            ptr_q       <= ptr_d;
            sda_oe_q    <= sda_oe_d;
            busy_q      <= busy_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
            regs_q      <= regs_d;
        end
    end

    // Gating with reset_n releases the line combinationally the moment reset asserts
    assign sda       = (sda_oe_q && reset_n) ? 1'b0 : 1'bz;
    assign regs_o    = regs_q;
    assign wr_strobe = wr_strobe_q;
    assign wr_addr   = wr_addr_q;
    assign busy      = busy_q;

endmodule
`default_nettype wire
